// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 constants, FSM state encoding and round helpers.
package sha1_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } sha1_state_e;

  // Chaining value loaded by reset and by init, H0 in the top word.
  localparam logic [159:0] H_INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  localparam logic [31:0] K_0_19  = 32'h5A827999;
  localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
  localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
  localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  // Boolean function of b, c, d selected by round index.
  function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
    end else begin
      f = b ^ c ^ d;
    end
    return f;
  endfunction

  // Additive round constant selected by round index.
  function automatic logic [31:0] k_sel(input logic [6:0] t);
    logic [31:0] k;
    if (t < 7'd20) begin
      k = K_0_19;
    end else if (t < 7'd40) begin
      k = K_20_39;
    end else if (t < 7'd60) begin
      k = K_40_59;
    end else begin
      k = K_60_79;
    end
    return k;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round step on the a..e working set.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  t_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  assign a_o = rotl5(a_i) + f_sel(t_i, b_i, c_i, d_i) + e_i + k_sel(t_i) + w_i;
  assign b_o = a_i;
  assign c_o = rotl30(b_i);
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/sha1_block_ctrl.sv
// sha1_block_ctrl: loads a 16-word block, runs 80 SHA-1 rounds, folds into H.
// Build option SHA1_CTRL_UNROLL2_EN: two chained rounds per cycle (40 cycles).
module sha1_block_ctrl
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [31:0]  word_data,
  output logic         busy,
  output logic         digest_valid,
  output logic [159:0] digest
);

  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_ROUND = ST_ROUND;
  localparam logic [1:0] S_FINAL = ST_FINAL;

`ifdef SHA1_CTRL_UNROLL2_EN
  localparam logic [6:0] T_STEP = 7'd2;
  localparam logic [6:0] T_LAST = 7'd78;
`else
  localparam logic [6:0] T_STEP = 7'd1;
  localparam logic [6:0] T_LAST = 7'd79;
`endif

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [6:0]   t_q, t_d;
  logic [159:0] h_q, h_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d;
  logic         dv_q, dv_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];

  logic [3:0]   i0_s;
  logic [31:0]  w0_s;
  logic [31:0]  ra_s, rb_s, rc_s, rd_s, re_s;
  logic [31:0]  r0a_s, r0b_s, r0c_s, r0d_s, r0e_s;

  assign i0_s = t_q[3:0];

  // Schedule word for the first round of this cycle (buffer or expansion).
  always_comb begin
    logic [3:0] im3, im8, im14;
    im3  = i0_s - 4'd3;
    im8  = i0_s - 4'd8;
    im14 = i0_s - 4'd14;
    if (t_q < 7'd16) begin
      w0_s = w_q[i0_s];
    end else begin
      w0_s = rotl1(w_q[im3] ^ w_q[im8] ^ w_q[im14] ^ w_q[i0_s]);
    end
  end

  sha1_round u_round0 (
    .a_i(a_q), .b_i(b_q), .c_i(c_q), .d_i(d_q), .e_i(e_q),
    .w_i(w0_s), .t_i(t_q),
    .a_o(r0a_s), .b_o(r0b_s), .c_o(r0c_s), .d_o(r0d_s), .e_o(r0e_s)
  );

`ifdef SHA1_CTRL_UNROLL2_EN
  logic [6:0]  t1_s;
  logic [3:0]  i1_s;
  logic [31:0] w1_s;

  assign t1_s = t_q + 7'd1;
  assign i1_s = t1_s[3:0];

  // Schedule word for the second round; none of its taps is slot t&15.
  always_comb begin
    logic [3:0] jm3, jm8, jm14;
    jm3  = i1_s - 4'd3;
    jm8  = i1_s - 4'd8;
    jm14 = i1_s - 4'd14;
    if (t1_s < 7'd16) begin
      w1_s = w_q[i1_s];
    end else begin
      w1_s = rotl1(w_q[jm3] ^ w_q[jm8] ^ w_q[jm14] ^ w_q[i1_s]);
    end
  end

  sha1_round u_round1 (
    .a_i(r0a_s), .b_i(r0b_s), .c_i(r0c_s), .d_i(r0d_s), .e_i(r0e_s),
    .w_i(w1_s), .t_i(t1_s),
    .a_o(ra_s), .b_o(rb_s), .c_o(rc_s), .d_o(rd_s), .e_o(re_s)
  );
`else
  assign ra_s = r0a_s;
  assign rb_s = r0b_s;
  assign rc_s = r0c_s;
  assign rd_s = r0d_s;
  assign re_s = r0e_s;
`endif

  assign word_ready   = (state_q == S_LOAD) && !init;
  assign busy         = (state_q != S_LOAD);
  assign digest_valid = dv_q;
  assign digest       = h_q;

  // Next-state logic: init has priority over everything, then the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    h_d     = h_q;
    dv_d    = dv_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q;
    for (int i = 0; i < 16; i++) begin
      w_d[i] = w_q[i];
    end
    if (init) begin
      state_d = S_LOAD;
      cnt_d   = 4'd0;
      t_d     = 7'd0;
      h_d     = H_INIT;
      dv_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (word_valid) begin
            w_d[cnt_q] = word_data;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
              dv_d = 1'b0;
            end else begin
              dv_d = dv_q;
            end
            if (cnt_q == 4'd15) begin
              a_d = h_q[159:128]; b_d = h_q[127:96]; c_d = h_q[95:64];
              d_d = h_q[63:32];   e_d = h_q[31:0];
              dv_d    = 1'b0;
              t_d     = 7'd0;
              state_d = S_ROUND;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_ROUND: begin
          a_d = ra_s; b_d = rb_s; c_d = rc_s; d_d = rd_s; e_d = re_s;
          w_d[i0_s] = w0_s;
`ifdef SHA1_CTRL_UNROLL2_EN
          w_d[i1_s] = w1_s;
`endif
          if (t_q == T_LAST) begin
            t_d     = 7'd0;
            state_d = S_FINAL;
          end else begin
            t_d     = t_q + T_STEP;
            state_d = S_ROUND;
          end
        end
        S_FINAL: begin
          h_d = {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
                 h_q[63:32] + d_q, h_q[31:0] + e_q};
          dv_d    = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_LOAD;
        end
        default: begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
          t_d     = 7'd0;
        end
      endcase
    end
  end

  // State, counters, chaining value, working set and schedule buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 7'd0;
      h_q     <= H_INIT;
      dv_q    <= 1'b0;
      a_q <= 32'd0; b_q <= 32'd0; c_q <= 32'd0; d_q <= 32'd0; e_q <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      h_q     <= h_d;
      dv_q    <= dv_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha1_block_ctrl.sv
// tb_sha1_block_ctrl: directed known-answer checks for sha1_block_ctrl.
module tb_sha1_block_ctrl;

`ifdef SHA1_CTRL_UNROLL2_EN
  localparam int EXP_LAT = 42;
`else
  localparam int EXP_LAT = 82;
`endif

  localparam logic [159:0] H_INIT_EXP = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] ABC_DIG    = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] EMPTY_DIG  = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] TWO_DIG    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         busy;
  logic         digest_valid;
  logic [159:0] digest;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sha1_block_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .busy(busy), .digest_valid(digest_valid), .digest(digest)
  );

  task automatic pulse_init();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
  endtask

  // Presents 16 words; returns mid-cycle of the cycle whose edge takes the last word.
  task automatic send_block(input logic [511:0] blk, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < 16 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        word_valid = 1'b0;
      end else begin
        word_valid = 1'b1;
        word_data  = blk[511 - 32*i -: 32];
        if (word_ready) i++;
      end
    end
    checks++;
    if (i != 16) begin
      fails++;
      $display("FAIL send_block words_accepted got %0d want 16", i);
    end
  endtask

  // Counts cycles from the last accepted word until digest_valid; watches word_ready.
  task automatic wait_digest(output int lat, output int ready_bad, input bit hold);
    lat = 0;
    ready_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy && word_ready) ready_bad++;
      if (hold && busy) begin
        word_valid = 1'b1;
        word_data  = 32'hdeadbeef;
      end else begin
        word_valid = 1'b0;
      end
    end while (!digest_valid && lat < 500);
  endtask

  task automatic test_reset();
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", word_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got %b want 0", digest_valid); end
    checks++; if (digest !== H_INIT_EXP) begin fails++; $display("FAIL reset_digest got %h want %h", digest, H_INIT_EXP); end
  endtask

  task automatic test_abc();
    int lat, bad;
    pulse_init();
    send_block(ABC_BLK, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (lat != EXP_LAT) begin fails++; $display("FAIL abc_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (digest !== ABC_DIG) begin fails++; $display("FAIL abc_digest got %h want %h", digest, ABC_DIG); end
    checks++; if (bad != 0) begin fails++; $display("FAIL abc_ready_busy got %0d want 0", bad); end
  endtask

  task automatic test_empty();
    int lat, bad;
    pulse_init();
    send_block(EMPTY_BLK, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (lat != EXP_LAT) begin fails++; $display("FAIL empty_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (digest !== EMPTY_DIG) begin fails++; $display("FAIL empty_digest got %h want %h", digest, EMPTY_DIG); end
  endtask

  task automatic test_two_block();
    int lat, bad;
    pulse_init();
    send_block(TWO_BLK1, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (digest_valid !== 1'b1) begin fails++; $display("FAIL two_blk1_dv got %b want 1", digest_valid); end
    send_block(TWO_BLK2, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (lat != EXP_LAT) begin fails++; $display("FAIL two_blk2_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (digest !== TWO_DIG) begin fails++; $display("FAIL two_digest got %h want %h", digest, TWO_DIG); end
  endtask

  task automatic test_gaps_hold();
    int lat, bad;
    pulse_init();
    send_block(ABC_BLK, 1'b1);
    wait_digest(lat, bad, 1'b1);
    checks++; if (bad != 0) begin fails++; $display("FAIL gaps_ready_busy got %0d want 0", bad); end
    checks++; if (lat != EXP_LAT) begin fails++; $display("FAIL gaps_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (digest !== ABC_DIG) begin fails++; $display("FAIL gaps_digest got %h want %h", digest, ABC_DIG); end
  endtask

  task automatic test_init_abort();
    int lat, bad;
    send_block(EMPTY_BLK, 1'b0);
    @(negedge clk); word_valid = 1'b0;
    repeat (37) @(negedge clk);
    init = 1'b1; word_valid = 1'b1; word_data = 32'h12345678;
    #1;
    checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL init_round_ready got %b want 0", word_ready); end
    @(negedge clk); init = 1'b0; word_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL init_busy got %b want 0", busy); end
    checks++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL init_dv got %b want 0", digest_valid); end
    checks++; if (digest !== H_INIT_EXP) begin fails++; $display("FAIL init_digest got %h want %h", digest, H_INIT_EXP); end
    @(negedge clk);
    init = 1'b1; word_valid = 1'b1; word_data = 32'hcafef00d;
    #1;
    checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL init_load_ready got %b want 0", word_ready); end
    @(negedge clk); init = 1'b0; word_valid = 1'b0;
    send_block(ABC_BLK, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (digest !== ABC_DIG) begin fails++; $display("FAIL init_abc_digest got %h want %h", digest, ABC_DIG); end
  endtask

  task automatic test_async_reset();
    int lat, bad;
    // Mid-LOAD: five words taken, digest holds the previous result.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); word_valid = 1'b1; word_data = TWO_BLK1[511 - 32*i -: 32];
    end
    @(negedge clk); word_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL rstload_ready got %b want 1", word_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstload_busy got %b want 0", busy); end
    checks++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL rstload_dv got %b want 0", digest_valid); end
    checks++; if (digest !== H_INIT_EXP) begin fails++; $display("FAIL rstload_digest got %h want %h", digest, H_INIT_EXP); end
    @(negedge clk); reset = 1'b0;
    // Mid-ROUND.
    send_block(ABC_BLK, 1'b0);
    @(negedge clk); word_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstround_pre_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL rstround_ready got %b want 1", word_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstround_busy got %b want 0", busy); end
    checks++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL rstround_dv got %b want 0", digest_valid); end
    @(negedge clk); reset = 1'b0;
    send_block(EMPTY_BLK, 1'b0);
    wait_digest(lat, bad, 1'b0);
    checks++; if (digest !== EMPTY_DIG) begin fails++; $display("FAIL rst_after_digest got %h want %h", digest, EMPTY_DIG); end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; word_valid = 1'b0; word_data = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_gaps_hold();
    test_init_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
